se_excite_scaler: RTL and testbench
===================================

# se_excite_scaler

Squeeze-and-excite "excite" stage for the MobileNetV3 datapath. It consumes the per-channel gate stream produced by the `hsigmoid` activation, holds one gate per channel, and then multiplies a channel-interleaved feature-map stream by the matching gate. It sits between the SE gate path (`hsigmoid` output) and the block's projection convolution. It is the downstream consumer of the activation units' `valid_out` protocol.

## Interface
- `DATA_WIDTH`, 8, signed fixed-point word width for gates, features and outputs.
- `FRAC_BITS`, 4, number of fractional bits; a gate of 1.0 is `1 << FRAC_BITS`.
- `NUM_CHANNELS`, 16, channels per frame; also the number of gates.
- `NUM_PIXELS`, 49, spatial positions per frame; each position carries `NUM_CHANNELS` features.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `gate_in` in DATA_WIDTH: signed gate value from `hsigmoid`.
- `gate_valid_in` in 1: `gate_in` is valid this cycle.
- `feat_in` in DATA_WIDTH: signed feature; channel-fastest order.
- `feat_valid_in` in 1: `feat_in` is valid this cycle.
- `feat_ready_out` in the out direction, 1 bit: high only in APPLY; a feature is accepted when `feat_valid_in && feat_ready_out`.
- `data_out` out DATA_WIDTH: scaled feature.
- `valid_out` out 1: `data_out` is valid.
- `frame_done` out 1: one-cycle pulse coincident with the last output of a frame.

## Operation
- Reset: the state goes to LOAD. The gate index, channel counter and pixel counter go to 0. `data_out`=0, `valid_out`=0, `frame_done`=0, `feat_ready_out`=0. Gate registers are cleared to 0. The same applies to a reset mid-frame: in-flight pipeline data is discarded and no `valid_out` is asserted afterwards.
- LOAD state:
  - Each `gate_valid_in` writes the clamped gate to `gate[idx]`, then `idx++`.
  - Clamping: gate<0 becomes 0; gate>`1<<FRAC_BITS` becomes `1<<FRAC_BITS`.
  - When the write hits `idx==NUM_CHANNELS-1`, move to APPLY on the next cycle and reset `idx` to 0.
  - `feat_valid_in` is ignored (dropped) while in LOAD.
- APPLY state:
  - Each accepted feature is multiplied by `gate[ch]`; `ch` wraps from `NUM_CHANNELS-1` to 0.
  - On each wrap, `pix++`.
  - When the accept hits `ch==NUM_CHANNELS-1` and `pix==NUM_PIXELS-1`, return to LOAD.
  - The last output carries `frame_done`.
  - `gate_valid_in` is ignored while in APPLY; gates are never overwritten mid-frame.
- Arithmetic:
  - The product is `2*DATA_WIDTH` bits signed.
  - The result is `product >>> FRAC_BITS` (floor), truncated to DATA_WIDTH.
  - Because 0 ≤ gate ≤ 1.0, the result always fits; there is no saturation logic.
- Simultaneous gate and feature valid inputs: only the one matching the current state is used.

## Timing
- Gate write: the value is visible to APPLY no earlier than the cycle after the state transition. The transition takes effect the cycle after the final gate write.
- Feature path latency is 2 cycles:
  - Stage 1 registers the product and carries `valid` and last-flag.
  - Stage 2 registers the shifted result into `data_out`, `valid_out` and `frame_done`.
- Throughput is one feature per cycle in APPLY.
- `data_out` holds its last value when `valid_out`=0.
- `feat_ready_out` drops in the cycle after the final feature is accepted.
- The pipeline drains independently of state, so the last two outputs can emerge while in LOAD.
- Back-to-back frames are allowed: the next frame's gates may arrive while the previous frame's results drain.

## Configuration
- `SE_SCALER_ROUND_EN`:
  - Defined: round-half-up, i.e. `(product + (1 << (FRAC_BITS-1))) >>> FRAC_BITS`.
  - Undefined: floor (plain arithmetic shift).
  - Latency and handshake are identical in both builds.

## Structure
- Shared package `se_pkg`:
  - the state enum `{SE_LOAD, SE_APPLY}`;
  - `GATE_ONE` (`1 << FRAC_BITS`) as a parameter function or localparam helper;
  - the counter width helpers (`$clog2` of NUM_CHANNELS and NUM_PIXELS).
- Sub-module `se_gate_bank`:
  - a NUM_CHANNELS × DATA_WIDTH register file;
  - a clamping write port (index, data, enable);
  - a combinational read by channel index;
  - synchronous reset to 0.
- The top level holds the FSM, the counters and the 2-stage multiply pipeline.

## Test plan
- Reset and load: after reset, load 16 gates of 16 (1.0), then stream feature 40 on all channels. Expect `data_out`=40 on every output, `valid_out` exactly 2 cycles after each accept, and `frame_done` only on output 784.
- Rounding: gate 8 (0.5) on ch0, feature -7. Expect `data_out`=-4 without `SE_SCALER_ROUND_EN` and -3 with it.
- Clamping: gates 20 and -5 loaded on ch0 and ch1; features 127 and 50. Expect outputs 127 and 0.
- Protocol: feature valid asserted during LOAD gives no `valid_out` and `feat_ready_out`=0. Gate valid asserted during APPLY leaves the gates unchanged: with gate 16 and feature 10, the output stays 10.
- Reset mid-frame: assert `rst` after 100 features. Expect `valid_out`=0 from the next cycle, state LOAD, and `feat_ready_out`=0. A fresh gate load then works from ch0.
- Back-to-back: start the next frame's gate load immediately after the last accept. Expect the final two outputs of frame 1 to appear correctly and frame 2 to produce its outputs unaffected.

Source files
------------

// File: rtl/se_pkg.sv
// Shared state type and sizing helpers for the squeeze-and-excite scaler.
package se_pkg;

  typedef enum logic {
    SE_LOAD  = 1'b0,
    SE_APPLY = 1'b1
  } se_state_e;

  // Fixed-point representation of a gate of exactly 1.0.
  function automatic int gate_one(input int frac_bits);
    return 1 << frac_bits;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/se_gate_bank.sv
// Per-channel gate register file: clamps each write into [0, 1.0] and offers
// a combinational read by channel index.
module se_gate_bank
  import se_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAC_BITS    = 4,
  parameter int NUM_CHANNELS = 16,
  parameter int IDX_W        = cnt_width(NUM_CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_i,
  input  logic [IDX_W-1:0]             wr_idx_i,
  input  logic signed [DATA_WIDTH-1:0] wr_data_i,
  input  logic [IDX_W-1:0]             rd_idx_i,
  output logic signed [DATA_WIDTH-1:0] rd_data_o
);

  localparam logic signed [DATA_WIDTH-1:0] GATE_MAX = DATA_WIDTH'(gate_one(FRAC_BITS));

  logic signed [DATA_WIDTH-1:0] gate_q [NUM_CHANNELS];
  logic signed [DATA_WIDTH-1:0] wr_clamped;

  always_comb begin
    // NOTE: default assignment first, so no path leaves wr_clamped unassigned and no latch is inferred.
    wr_clamped = wr_data_i;
    if (wr_data_i[DATA_WIDTH-1]) begin
      wr_clamped = '0;
    end else if (wr_data_i > GATE_MAX) begin
      wr_clamped = GATE_MAX;
    end
  end

  // NOTE: every flop below uses <= so all state updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: resetting the whole array keeps it as flops rather than a RAM; gates must read 0 after reset.
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        gate_q[c] <= '0;
      end
    end else if (wr_en_i) begin
      gate_q[wr_idx_i] <= wr_clamped;
    end
  end

  assign rd_data_o = gate_q[rd_idx_i];

endmodule

// File: rtl/se_excite_scaler.sv
// SE excite stage: loads one gate per channel, then scales a channel-fastest
// feature stream by the matching gate. Define SE_SCALER_ROUND_EN for round-half-up.
module se_excite_scaler
  import se_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAC_BITS    = 4,
  parameter int NUM_CHANNELS = 16,
  parameter int NUM_PIXELS   = 49
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] gate_in,
  input  logic                         gate_valid_in,
  input  logic signed [DATA_WIDTH-1:0] feat_in,
  input  logic                         feat_valid_in,
  output logic                         feat_ready_out,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         valid_out,
  output logic                         frame_done
);

  localparam int CH_W   = cnt_width(NUM_CHANNELS);
  localparam int PIX_W  = cnt_width(NUM_PIXELS);
  localparam int PROD_W = 2 * DATA_WIDTH;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIXELS - 1);

  se_state_e                    state_q;
  logic [CH_W-1:0]              idx_q;
  logic [CH_W-1:0]              ch_q;
  logic [PIX_W-1:0]             pix_q;
  logic                         ready_q;

  logic                         s1_valid_q;
  logic                         s1_last_q;
  logic signed [PROD_W-1:0]     prod_q;
  logic signed [DATA_WIDTH-1:0] data_q;
  logic                         valid_q;
  logic                         done_q;

  logic                         gate_wr_en;
  logic                         feat_accept;
  logic                         last_accept;
  logic signed [DATA_WIDTH-1:0] gate_rd;
  logic signed [PROD_W-1:0]     prod_d;
  logic signed [PROD_W-1:0]     biased_d;

  assign gate_wr_en  = (state_q == SE_LOAD) && gate_valid_in;
  assign feat_accept = feat_valid_in && ready_q;
  assign last_accept = feat_accept && (ch_q == CH_LAST) && (pix_q == PIX_LAST);

  se_gate_bank #(
    .DATA_WIDTH  (DATA_WIDTH),
    .FRAC_BITS   (FRAC_BITS),
    .NUM_CHANNELS(NUM_CHANNELS),
    .IDX_W       (CH_W)
  ) u_gate_bank (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (gate_wr_en),
    .wr_idx_i (idx_q),
    .wr_data_i(gate_in),
    .rd_idx_i (ch_q),
    .rd_data_o(gate_rd)
  );

  // ready_q mirrors the APPLY state so the handshake comes straight off a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SE_LOAD;
      idx_q   <= '0;
      ch_q    <= '0;
      pix_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        SE_LOAD: begin
          if (gate_valid_in) begin
            if (idx_q == CH_LAST) begin
              idx_q   <= '0;
              state_q <= SE_APPLY;
              ready_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        SE_APPLY: begin
          if (feat_accept) begin
            if (ch_q == CH_LAST) begin
              ch_q <= '0;
              if (pix_q == PIX_LAST) begin
                pix_q   <= '0;
                state_q <= SE_LOAD;
                ready_q <= 1'b0;
              end else begin
                pix_q <= pix_q + 1'b1;
              end
            end else begin
              ch_q <= ch_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= SE_LOAD;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign prod_d = $signed({{DATA_WIDTH{feat_in[DATA_WIDTH-1]}}, feat_in}) *
                  $signed({{DATA_WIDTH{gate_rd[DATA_WIDTH-1]}}, gate_rd});

`ifdef SE_SCALER_ROUND_EN
  localparam logic signed [PROD_W-1:0] HALF_LSB = PROD_W'(1 << (FRAC_BITS - 1));
  assign biased_d = prod_q + HALF_LSB;
`else
  assign biased_d = prod_q;
`endif

  // The pipeline drains regardless of FSM state; only reset discards it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      prod_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      s1_valid_q <= feat_accept;
      s1_last_q  <= last_accept;
      if (feat_accept) begin
        prod_q <= prod_d;
      end
      valid_q <= s1_valid_q;
      done_q  <= s1_last_q;
      if (s1_valid_q) begin
        data_q <= DATA_WIDTH'(biased_d >>> FRAC_BITS);
      end
    end
  end

  assign feat_ready_out = ready_q;
  assign data_out       = data_q;
  assign valid_out      = valid_q;
  assign frame_done     = done_q;

endmodule

// File: tb/tb_se_excite_scaler.sv
// Directed bench for se_excite_scaler: full frames, rounding, clamping,
// handshake rules, mid-frame reset and back-to-back frames.
`timescale 1ns/1ps
module tb_se_excite_scaler;

  localparam int DW    = 8;
  localparam int FB    = 4;
  localparam int NC    = 16;
  localparam int NP    = 49;
  localparam int FRAME = NC * NP;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] gate_in;
  logic                 gate_valid_in;
  logic signed [DW-1:0] feat_in;
  logic                 feat_valid_in;
  logic                 feat_ready_out;
  logic signed [DW-1:0] data_out;
  logic                 valid_out;
  logic                 frame_done;

  se_excite_scaler #(
    .DATA_WIDTH  (DW),
    .FRAC_BITS   (FB),
    .NUM_CHANNELS(NC),
    .NUM_PIXELS  (NP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .gate_in       (gate_in),
    .gate_valid_in (gate_valid_in),
    .feat_in       (feat_in),
    .feat_valid_in (feat_valid_in),
    .feat_ready_out(feat_ready_out),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int stray_done  = 0;

  int acc_q[$];
  int out_cyc_q[$];
  int out_data_q[$];
  bit out_done_q[$];
  int exp_q[$];
  bit exp_done_q[$];
  int gates_v[NC];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (feat_valid_in && feat_ready_out) acc_q.push_back(cyc);
    if (valid_out) begin
      out_data_q.push_back(int'(data_out));
      out_done_q.push_back(frame_done);
      out_cyc_q.push_back(cyc);
    end else if (frame_done) begin
      stray_done++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    acc_q.delete();
    out_cyc_q.delete();
    out_data_q.delete();
    out_done_q.delete();
    exp_q.delete();
    exp_done_q.delete();
    stray_done = 0;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    gate_valid_in = 1'b0;
    gate_in       = '0;
    feat_valid_in = 1'b0;
    feat_in       = '0;
    tick();
    tick();
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic load_gates();
    for (int c = 0; c < NC; c++) begin
      gate_valid_in = 1'b1;
      gate_in       = gates_v[c][DW-1:0];
      tick();
    end
    gate_valid_in = 1'b0;
  endtask

  function automatic int feat_val(input int mode, input int i);
    case (mode)
      0:       return 40;
      1:       return 16 * ((i % 5) - 2);
      default: return 16 * ((i % 3) - 1);
    endcase
  endfunction

  // Hand-derived results: features are multiples of 16, so both builds agree.
  function automatic int exp_val(input int mode, input int i);
    case (mode)
      0:       return 40;
      1:       return ((i % 5) - 2) * ((i % NC) + 1);
      default: return 8 * ((i % 3) - 1);
    endcase
  endfunction

  task automatic stream(input int mode, input int n);
    for (int i = 0; i < n; i++) begin
      feat_valid_in = 1'b1;
      feat_in       = DW'(feat_val(mode, i));
      exp_q.push_back(exp_val(mode, i));
      exp_done_q.push_back((i % FRAME) == FRAME - 1);
      tick();
    end
    feat_valid_in = 1'b0;
  endtask

  task automatic send_one(input int f, input int e);
    feat_valid_in = 1'b1;
    feat_in       = DW'(f);
    exp_q.push_back(e);
    exp_done_q.push_back(1'b0);
    tick();
    feat_valid_in = 1'b0;
  endtask

  task automatic verify(input string tag);
    int n;
    int lat_err  = 0;
    int done_err = 0;
    check({tag, "_count"}, out_data_q.size(), exp_q.size());
    n = (out_data_q.size() < exp_q.size()) ? out_data_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data[%0d]", tag, i), out_data_q[i], exp_q[i]);
      if (out_done_q[i] !== exp_done_q[i]) done_err++;
    end
    n = (out_cyc_q.size() < acc_q.size()) ? out_cyc_q.size() : acc_q.size();
    for (int i = 0; i < n; i++) begin
      if (out_cyc_q[i] - acc_q[i] != 2) lat_err++;
    end
    check({tag, "_latency_errs"}, lat_err, 0);
    check({tag, "_done_errs"}, done_err, 0);
    check({tag, "_stray_done"}, stray_done, 0);
  endtask

  initial begin
    // Reset state, unity gates, full frame of 40s.
    do_reset();
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_done", frame_done, 0);
    check("rst_ready", feat_ready_out, 0);
    for (int c = 0; c < NC; c++) gates_v[c] = 16;
    load_gates();
    check("load_ready", feat_ready_out, 1);
    stream(0, FRAME);
    check("ready_drop", feat_ready_out, 0);
    repeat (4) tick();
    verify("unity");

    // Rounding: gate 0.5, feature -7 (-3.5).
    do_reset();
    gates_v[0] = 8;
    load_gates();
`ifdef SE_SCALER_ROUND_EN
    send_one(-7, -3);
`else
    send_one(-7, -4);
`endif
    repeat (4) tick();
    verify("round");

    // Clamping on write, plus boundary feature values.
    do_reset();
    gates_v[0] = 20;
    gates_v[1] = -5;
    gates_v[2] = 17;
    gates_v[3] = 5;
    gates_v[4] = 12;
    gates_v[5] = 1;
    load_gates();
    send_one(127, 127);
    send_one(50, 0);
    send_one(-128, -128);
    send_one(100, 31);
    send_one(-100, -75);
    send_one(99, 6);
    repeat (4) tick();
    verify("clamp");

    // Features during LOAD are dropped; gates during APPLY are ignored.
    do_reset();
    for (int c = 0; c < NC; c++) gates_v[c] = 16;
    feat_valid_in = 1'b1;
    feat_in       = 8'sd99;
    repeat (5) tick();
    check("load_ready_low", feat_ready_out, 0);
    check("load_no_valid", valid_out, 0);
    load_gates();
    for (int i = 0; i < 2 * NC; i++) begin
      gate_valid_in = (i < NC);
      gate_in       = '0;
      feat_valid_in = 1'b1;
      feat_in       = 8'sd10;
      exp_q.push_back(10);
      exp_done_q.push_back(1'b0);
      tick();
    end
    gate_valid_in = 1'b0;
    feat_valid_in = 1'b0;
    repeat (4) tick();
    verify("proto");

    // Reset after 100 features, then a fresh load from channel 0.
    do_reset();
    load_gates();
    stream(0, 100);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_ready", feat_ready_out, 0);
    rst = 1'b0;
    clear_mon();
    repeat (3) tick();
    check("mid_rst_quiet", out_data_q.size(), 0);
    for (int c = 0; c < NC; c++) gates_v[c] = c + 1;
    load_gates();
    for (int c = 0; c < NC; c++) send_one(32, 2 * (c + 1));
    repeat (4) tick();
    verify("reload");

    // Back-to-back frames: frame 2 gates load while frame 1 drains.
    do_reset();
    for (int c = 0; c < NC; c++) gates_v[c] = c + 1;
    load_gates();
    stream(1, FRAME);
    for (int c = 0; c < NC; c++) gates_v[c] = 8;
    load_gates();
    check("b2b_ready", feat_ready_out, 1);
    stream(2, FRAME);
    repeat (4) tick();
    verify("b2b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
